// File: rtl/i2s_tx_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2s_tx_param : parameterised I2S / left-justified serial transmitter |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module i2s_tx_param #(
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 16,
  parameter int BCK_DIV = 4,
  parameter int MODE    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  input  logic              mute,
  output logic              bck,
  output logic              ws,
  output logic              sdata,
  output logic              frame_tick,
  output logic              underrun
);

  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int B_W   = $clog2(2 * SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(2 * SLOT_W - 1);
  localparam logic [B_W-1:0]   SLOT_C   = B_W'(SLOT_W);
  localparam logic [B_W-1:0]   DATA_C   = B_W'(DATA_W);

  logic [DIV_W-1:0]    div_q, div_d;
  logic                bck_q, bck_d;
  logic [B_W-1:0]      b_q, b_d;
  logic [2*DATA_W-1:0] pending_q, pending_d;
  logic                pending_full_q, pending_full_d;
  logic [2*DATA_W-1:0] active_q, active_d;
  logic                ws_q, ws_d;
  logic                sdata_q, sdata_d;
  logic                delay_q, delay_d;
  logic                frame_tick_q, frame_tick_d;
  logic                underrun_q, underrun_d;

  logic                bck_wrap;
  logic                fall;
  logic                frame_start;
  logic                right_slot;
  logic [B_W-1:0]      pos;
  logic [DATA_W-1:0]   chan;
  logic [DATA_W-1:0]   chan_sh;
  logic                lj_bit;

  always_comb begin
    div_d          = div_q;
    bck_d          = bck_q;
    b_d            = b_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    active_d       = active_q;
    ws_d           = ws_q;
    sdata_d        = sdata_q;
    delay_d        = delay_q;

    bck_wrap = (div_q == DIV_LAST);
    div_d    = bck_wrap ? '0 : div_q + DIV_W'(1);
    bck_d    = bck_wrap ? ~bck_q : bck_q;

    fall        = bck_wrap && bck_q;
    frame_start = fall && (b_q == B_LAST);
    if (fall) begin
      b_d = frame_start ? '0 : b_q + B_W'(1);
    end

    frame_tick_d = frame_start;
    underrun_d   = frame_start && !pending_full_q;

    // Frame-start consumption and the input handshake are exclusive on pending_full_q.
    if (frame_start) begin
      if (pending_full_q) begin
        active_d       = pending_q;
        pending_full_d = 1'b0;
      end
      if (mute) begin
        active_d = '0;
      end
    end
    if (s_valid && !pending_full_q) begin
      pending_d      = {s_left, s_right};
      pending_full_d = 1'b1;
    end

    right_slot = (b_d >= SLOT_C);
    pos        = right_slot ? b_d - SLOT_C : b_d;
    chan       = right_slot ? active_d[DATA_W-1:0] : active_d[2*DATA_W-1:DATA_W];
    chan_sh    = chan << pos;
    lj_bit     = (pos < DATA_C) ? chan_sh[DATA_W-1] : 1'b0;

    if (fall) begin
      ws_d    = right_slot;
      delay_d = lj_bit;
      sdata_d = (MODE == 1) ? lj_bit : delay_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q          <= '0;
      bck_q          <= 1'b0;
      b_q            <= B_LAST;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      active_q       <= '0;
      ws_q           <= 1'b0;
      sdata_q        <= 1'b0;
      delay_q        <= 1'b0;
      frame_tick_q   <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      div_q          <= div_d;
      bck_q          <= bck_d;
      b_q            <= b_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      active_q       <= active_d;
      ws_q           <= ws_d;
      sdata_q        <= sdata_d;
      delay_q        <= delay_d;
      frame_tick_q   <= frame_tick_d;
      underrun_q     <= underrun_d;
    end
  end

  assign s_ready    = !pending_full_q;
  assign bck        = bck_q;
  assign ws         = ws_q;
  assign sdata      = sdata_q;
  assign frame_tick = frame_tick_q;
  assign underrun   = underrun_q;

endmodule
`default_nettype wire

// File: doc/i2s_tx_param.md
I2S_TX_PARAM -- requirements
Module: i2s_tx_param

Interface
REQ-001 SHALL provide parameters: DATA_W, default 16, sample width per channel, legal 8..32.
REQ-002 SHALL provide parameter SLOT_W, default 16, BCK periods per channel slot, legal DATA_W..32.
REQ-003 SHALL provide parameter BCK_DIV, default 4, clk cycles per BCK half-period, legal >=1.
REQ-004 SHALL provide parameter MODE, default 0, where 0 = Philips I2S (one-bit delay) and 1 = left-justified.
REQ-005 SHALL have one clock and an active-low asynchronous reset; the ports are listed below.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 s_valid  input  1  stereo sample offered.
REQ-009 s_ready  output  1  block can accept a sample this cycle.
REQ-010 s_left  input  DATA_W  left sample, two's complement.
REQ-011 s_right  input  DATA_W  right sample, two's complement.
REQ-012 mute  input  1  synchronous level; 1 forces transmitted samples to zero.
REQ-013 bck  output  1  registered bit clock.
REQ-014 ws  output  1  word select; 0 = left, 1 = right.
REQ-015 sdata  output  1  serial data, MSB first.
REQ-016 frame_tick  output  1  one-clk pulse at each frame start.
REQ-017 underrun  output  1  one-clk pulse when a frame starts with no sample pending.

Function
REQ-018 Divider: counter 0..BCK_DIV-1; at BCK_DIV-1 it SHALL wrap to 0 and toggle bck, giving a BCK period of 2*BCK_DIV clk.
REQ-019 Falling event: the clk edge on which bck goes 1->0; ws, sdata, frame_tick, underrun and the bit index b SHALL update only on falling events.
REQ-020 b SHALL count 0..2*SLOT_W-1 and wrap to 0; the falling event where b becomes 0 is frame start; the frame is 2*SLOT_W*2*BCK_DIV clk.
REQ-021 After reset, the first frame start SHALL occur on the falling event 2*BCK_DIV clk edges after rst_n deasserts.
REQ-022 Input buffer: one pending register; s_ready SHALL equal NOT pending_full; s_valid&&s_ready SHALL load {s_left,s_right} and set pending_full.
REQ-023 At frame start with pending_full, the pending sample SHALL move to the active register, clearing pending_full on the same edge; a simultaneous handshake on that edge SHALL not occur because s_ready=0.
REQ-024 At frame start with pending empty, active SHALL retain the previous sample (repeat) and underrun SHALL pulse with frame_tick.
REQ-025 mute SHALL be sampled at frame start; when 1, active SHALL load zeros while a pending sample is still consumed and discarded; mute changes mid-frame SHALL take effect at the next frame start.
REQ-026 ws SHALL equal (b >= SLOT_W) in both modes.
REQ-027 The left-justified stream SHALL be: for slot position p = b mod SLOT_W, bit DATA_W-1-p of the channel sample when p < DATA_W, else 0.
REQ-028 MODE=1: sdata SHALL equal the left-justified stream.
REQ-029 MODE=0: sdata SHALL equal the left-justified stream delayed by exactly one falling event, so the right LSB of frame n appears at b=0 of frame n+1.

Reset
REQ-030 While rst_n=0: bck=0, ws=0, sdata=0, frame_tick=0, underrun=0, s_ready=1, pending empty, active=0, divider=0, b=2*SLOT_W-1, delay flop=0.
REQ-031 Reset assertion mid-frame SHALL abort the frame immediately; no partial sample SHALL be emitted after release.

Verification (DATA_W=16, SLOT_W=16, BCK_DIV=2 unless stated)
REQ-032 MODE=1, sample L=A5C3 R=8001 pending before first frame -> b0..15: ws=0, sdata=1010010111000011; b16..31: ws=1, sdata=1000000000000001.
REQ-033 MODE=0, same samples -> sdata is the REQ-032 bit sequence shifted one BCK later; b0 of the next frame carries 1 (right LSB); ws is unchanged from REQ-032.
REQ-034 Backpressure: offer A/B on consecutive cycles -> A accepted, s_ready=0 until the next frame start, B accepted the cycle after, A then B transmitted.
REQ-035 Underrun: no s_valid after sample 1234/5678 -> next frame repeats 1234/5678 and underrun pulses once, coincident with frame_tick.
REQ-036 mute=1 with samples streaming -> all-zero sdata from the next frame start, s_ready still cycling once per frame; mute=0 -> data resumes at the following frame start.
REQ-037 DATA_W=8, SLOT_W=10, MODE=1, L=81 -> b0..9 sdata = 1000000100; rst_n pulsed at b=5 -> outputs zero, first frame start 4 clk after release.
